ramp_pulse_encoder: RTL and testbench
=====================================

Name: ramp_pulse_encoder

Overview:
- Digital-to-time encoder: the transmit-side counterpart of the single-slope ADC backend.
- Accepts a WIDTH-bit code over a valid/ready handshake and runs a full 0..2^WIDTH-1 ramp count. It asserts pulse_out once the ramp reaches the code, so a downstream edge sampler sees a rising edge whose position encodes the value.
- Also exports the ramp code (count) to drive the ramp DAC, plus ramp_start/done framing for the analog side and loopback test benches.

Parameters:
- WIDTH, 8, bit width of input code and ramp counter.
- GAP, 2, idle cycles after each ramp before a new code is accepted; legal range is 1 or more.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserts immediately, released synchronously to clk.
- in_valid  input  1  a code is presented on in_value.
- in_value  input  WIDTH  code to encode.
- in_ready  output  1  block can accept a code; transfer occurs on in_valid && in_ready at a rising edge.
- abort  input  1  terminates the current ramp.
- count  output  WIDTH  current ramp code for the DAC.
- ramp_start  output  1  one-cycle strobe, high while count==0 in RAMP.
- pulse_out  output  1  encoded level; rising edge marks the code position.
- busy  output  1  high in RAMP and GAP.
- done  output  1  one-cycle strobe at the end of a completed (non-aborted) ramp.

Behaviour:
- Reset (rst low): state=IDLE, code register=0, count=0, gap counter=0. All outputs are 0, including in_ready.
- Outputs are registered; there is no combinational path from inputs to outputs.
- States and transitions:
  - IDLE: in_ready=1, starting from the first rising edge after reset release. On handshake: latch in_value into code, count<=0, go to RAMP, in_ready<=0. Without in_valid, stay in IDLE.
  - RAMP: count increments by 1 each cycle, from 0 to 2^WIDTH-1. ramp_start=1 only in the first RAMP cycle, when count==0. When count==2^WIDTH-1 and there is no abort: next state is GAP and done=1 in that first GAP cycle. count returns to 0 and does not wrap into a second ramp.
  - GAP: lasts exactly GAP cycles, including the cycle carrying done. busy=1 throughout. Then go to IDLE and set in_ready=1.
- pulse_out timing:
  - pulse_out(t) = (state(t-1)==RAMP && count(t-1) >= code && no abort at t-1).
  - Rising edge occurs exactly 1 cycle after count==code.
  - High for 2^WIDTH - code consecutive cycles. The last high cycle is the done cycle; pulse_out is 0 from the second GAP cycle onward.
- Code boundaries:
  - code=0: pulse_out rises in the cycle after ramp_start.
  - code=2^WIDTH-1: pulse_out is high for exactly one cycle, coincident with done.
- Ramp length: total cycles from handshake edge to done = 2^WIDTH.
- abort:
  - In RAMP: next state is GAP, pulse_out<=0, count<=0, no done.
  - Abort on the final ramp cycle (count==max): abort wins; no done and no pulse_out in the following cycle.
  - In IDLE or GAP: abort is ignored.
- Handshake: in_valid while in_ready=0 is ignored; the code is not queued. in_value is sampled only on the handshake edge, so changes during RAMP have no effect.
- Mid-operation reset (rst asserted in any state): immediate return to the reset values above. After release, a new handshake is required.
- Width rule: the count >= code comparison is unsigned, WIDTH bits. The counter saturates at the state transition and never overflows.

Test Plan:
- Reset/idle (WIDTH=8, GAP=2): hold rst low, then release. Required: all outputs 0 during reset; in_ready=1 one edge after release; count stays 0 with no in_valid.
- Nominal code 100: in_value=100 with handshake.
  - ramp_start 1 cycle after the handshake edge.
  - pulse_out rises 101 cycles after ramp_start and stays high 156 cycles.
  - done on the 156th high cycle; in_ready returns 2 cycles after done.
- Boundaries:
  - code=0: pulse_out high 256 cycles, starting the cycle after ramp_start.
  - code=255: pulse_out high exactly 1 cycle, equal to the done cycle.
- Abort:
  - Abort at count=50 with code=20: pulse_out falls next cycle, no done, busy for 2 GAP cycles.
  - Abort at count=255: no done, no pulse.
- Handshake/back-to-back: in_valid held high with changing in_value during RAMP. Required: only the first code is encoded; the next code is accepted exactly GAP cycles after done; inter-ramp spacing is constant.
- Loopback and reset: feed pulse_out into the ADC backend edge sampler sharing count.
  - Random codes: captured value = code + fixed pipeline offset, identical for all codes.
  - rst pulsed mid-RAMP: all outputs 0 immediately, no done.

Source files
------------

// File: rtl/ramp_pulse_encoder.sv
// rtl/ramp_pulse_encoder.sv - digital-to-time encoder: one full ramp per code, pulse edge marks the code
module ramp_pulse_encoder #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  output logic             in_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             ramp_start,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [WIDTH-1:0] CMAX     = '1;
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] code;
  logic [GW-1:0]    gap_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      code       <= '0;
      count      <= '0;
      gap_cnt    <= '0;
      in_ready   <= 1'b0;
      ramp_start <= 1'b0;
      pulse_out  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ramp_start <= 1'b0;
      pulse_out  <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            code       <= in_value;
            count      <= '0;
            state      <= S_RAMP;
            in_ready   <= 1'b0;
            ramp_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_RAMP: begin
          // abort has priority over both the pulse and the end-of-ramp done
          if (abort) begin
            state   <= S_GAP;
            count   <= '0;
            gap_cnt <= GAP_LAST;
          end else begin
            pulse_out <= (count >= code);
            if (count == CMAX) begin
              state   <= S_GAP;
              count   <= '0;
              done    <= 1'b1;
              gap_cnt <= GAP_LAST;
            end else begin
              count <= count + WIDTH'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramp_pulse_encoder.sv
// tb/tb_ramp_pulse_encoder.sv - directed self-checking bench for ramp_pulse_encoder
module tb_ramp_pulse_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_value;
  logic       in_ready;
  logic       abort;
  logic [7:0] count;
  logic       ramp_start;
  logic       pulse_out;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // observations of one ramp, indexed by k = samples after the handshake edge
  int o_rs, o_pr, o_ph, o_pl, o_dn, o_dnn, o_rdy, o_cap, o_busy;

  ramp_pulse_encoder #(.WIDTH(8), .GAP(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
    .in_ready(in_ready), .abort(abort), .count(count), .ramp_start(ramp_start),
    .pulse_out(pulse_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic do_handshake(input logic [7:0] code);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_ready: in_ready=%b required 1 within 20 cycles", in_ready);
    end
    in_valid = 1'b1;
    in_value = code;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic observe(input int abort_k);
    logic prev_p = 1'b0;
    o_rs = -1; o_pr = -1; o_ph = 0; o_pl = -1; o_dn = -1; o_dnn = 0;
    o_rdy = -1; o_cap = -1; o_busy = 0;
    for (int k = 0; k < 300 && o_rdy < 0; k++) begin
      @(negedge clk);
      if (ramp_start && o_rs < 0) o_rs = k;
      if (pulse_out && !prev_p && o_pr < 0) begin
        o_pr  = k;
        o_cap = int'(count);
      end
      if (pulse_out) begin
        o_ph++;
        o_pl = k;
      end
      if (done) begin
        o_dnn++;
        if (o_dn < 0) o_dn = k;
      end
      if (busy) o_busy++;
      if (in_ready) o_rdy = k;
      prev_p = pulse_out;
      abort = (k == abort_k);
    end
    abort = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; in_value = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, ramp_start, pulse_out, busy, done} !== 5'b0 || count !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b count=%0d required 00000 and 0",
               {in_ready, ramp_start, pulse_out, busy, done}, count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: in_ready=%b required 1", in_ready);
    end
    begin
      int bad = 0;
      repeat (5) begin
        @(negedge clk);
        if (count !== 8'd0 || busy !== 1'b0 || in_ready !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL idle_hold: bad_cycles=%0d required 0", bad);
      end
    end
  endtask

  task automatic test_nominal;
    do_handshake(8'd100);
    observe(-1);
    checks++;
    if (o_rs !== 0) begin errors++; $display("FAIL nom_ramp_start: k=%0d required 0", o_rs); end
    checks++;
    if (o_pr !== 101) begin errors++; $display("FAIL nom_pulse_rise: k=%0d required 101", o_pr); end
    checks++;
    if (o_ph !== 156) begin errors++; $display("FAIL nom_pulse_len: %0d required 156", o_ph); end
    checks++;
    if (o_dn !== 256 || o_dnn !== 1 || o_pl !== 256) begin
      errors++;
      $display("FAIL nom_done: done_k=%0d n=%0d last_pulse=%0d required 256 1 256", o_dn, o_dnn, o_pl);
    end
    checks++;
    if (o_rdy !== 258) begin errors++; $display("FAIL nom_ready_back: k=%0d required 258", o_rdy); end
  endtask

  task automatic test_code_bounds;
    do_handshake(8'd0);
    observe(-1);
    checks++;
    if (o_pr !== 1 || o_ph !== 256 || o_dn !== 256) begin
      errors++;
      $display("FAIL code0: rise=%0d len=%0d done=%0d required 1 256 256", o_pr, o_ph, o_dn);
    end
    do_handshake(8'd255);
    observe(-1);
    checks++;
    if (o_pr !== 256 || o_ph !== 1 || o_dn !== 256 || o_pl !== 256) begin
      errors++;
      $display("FAIL code255: rise=%0d len=%0d done=%0d last=%0d required 256 1 256 256",
               o_pr, o_ph, o_dn, o_pl);
    end
  endtask

  task automatic test_abort;
    do_handshake(8'd20);
    observe(50);
    checks++;
    if (o_pr !== 21 || o_ph !== 30 || o_pl !== 50) begin
      errors++;
      $display("FAIL abort50_pulse: rise=%0d len=%0d last=%0d required 21 30 50", o_pr, o_ph, o_pl);
    end
    checks++;
    if (o_dnn !== 0 || o_rdy !== 53 || o_busy !== 53) begin
      errors++;
      $display("FAIL abort50_gap: done=%0d ready_k=%0d busy=%0d required 0 53 53", o_dnn, o_rdy, o_busy);
    end
    do_handshake(8'd255);
    observe(255);
    checks++;
    if (o_ph !== 0 || o_dnn !== 0 || o_rdy !== 258) begin
      errors++;
      $display("FAIL abort255: pulse=%0d done=%0d ready_k=%0d required 0 0 258", o_ph, o_dnn, o_rdy);
    end
  endtask

  task automatic test_back_to_back;
    int rs[3];
    int pr[3];
    int nrs = 0, npr = 0, ndn = 0;
    logic prev_p = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 8'd10;
    for (int k = 0; k < 790; k++) begin
      @(negedge clk);
      if (ramp_start && nrs < 3) begin rs[nrs] = k; nrs++; end
      if (pulse_out && !prev_p && npr < 3) begin pr[npr] = k; npr++; end
      if (done) ndn++;
      prev_p = pulse_out;
      if (k >= 519)                   in_valid = 1'b0;
      else if (k == 257 || k == 258)  in_value = 8'd40;
      else if (k == 516 || k == 517)  in_value = 8'd200;
      else                            in_value = 8'((k * 13) + 1);
    end
    in_valid = 1'b0;
    checks++;
    if (nrs !== 3 || ndn !== 3) begin
      errors++;
      $display("FAIL b2b_count: ramps=%0d dones=%0d required 3 3", nrs, ndn);
    end else begin
      checks++;
      if (rs[1] - rs[0] !== 259 || rs[2] - rs[1] !== 259) begin
        errors++;
        $display("FAIL b2b_spacing: %0d %0d required 259 259", rs[1] - rs[0], rs[2] - rs[1]);
      end
      checks++;
      if (npr !== 3 || pr[0] - rs[0] !== 11 || pr[1] - rs[1] !== 41 || pr[2] - rs[2] !== 201) begin
        errors++;
        $display("FAIL b2b_codes: rise offsets %0d %0d %0d required 11 41 201",
                 pr[0] - rs[0], pr[1] - rs[1], pr[2] - rs[2]);
      end
    end
  endtask

  task automatic test_loopback;
    logic [7:0] codes[3];
    codes[0] = 8'd3; codes[1] = 8'd77; codes[2] = 8'd200;
    for (int i = 0; i < 3; i++) begin
      do_handshake(codes[i]);
      observe(-1);
      checks++;
      if (o_cap - int'(codes[i]) !== 1) begin
        errors++;
        $display("FAIL loopback_%0d: captured=%0d required %0d", codes[i], o_cap, int'(codes[i]) + 1);
      end
    end
  endtask

  task automatic test_reset_mid_ramp;
    int bad = 0;
    do_handshake(8'd5);
    repeat (30) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, ramp_start, pulse_out, busy, done} !== 5'b0 || count !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: flags=%b count=%0d required 00000 and 0",
               {in_ready, ramp_start, pulse_out, busy, done}, count);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done || busy || pulse_out || count !== 8'd0) bad++;
    end
    checks++;
    if (bad != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: bad_cycles=%0d in_ready=%b required 0 1", bad, in_ready);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_code_bounds;
    test_abort;
    test_back_to_back;
    test_loopback;
    test_reset_mid_ramp;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
